ctrl_seq: RTL and testbench



---
 rtl/ctrl_seq_if.sv | 39 +++
 rtl/ctrl_seq.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ctrl_seq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: handshake and datapath-control bundle of the ctrl_seq
// sequencer. The master modport is the sequencer; the slave modport is the
// memory/datapath side (instruction/data memory, field splitter, ALU).
interface ctrl_seq_if;
  // instruction fetch port
  logic        imem_req;
  logic        imem_ack;
  logic [23:0] imem_rdata;
  // instruction register and split fields fed back from the splitter
  logic [23:0] ir;
  logic [5:0]  opc;
  logic [2:0]  funcode;
  // datapath control
  logic        alu_zero;
  logic [2:0]  alu_op;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        reg_we;
  logic        mem_to_reg;
  // data memory port
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  // fault reporting
  logic        trap;
  logic [1:0]  trap_cause;

  modport master (
    output imem_req, ir, alu_op, pc_en, pc_sel, reg_we, mem_to_reg,
           dmem_req, dmem_we, trap, trap_cause,
    input  imem_ack, imem_rdata, opc, funcode, alu_zero, dmem_ack
  );

  modport slave (
    input  imem_req, ir, alu_op, pc_en, pc_sel, reg_we, mem_to_reg,
           dmem_req, dmem_we, trap, trap_cause,
    output imem_ack, imem_rdata, opc, funcode, alu_zero, dmem_ack
  );
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer for the 24-bit RISC core.
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with a sticky TRAP state
// for illegal opcodes and memory acknowledge timeouts.
// Optional feature macro: CTRL_SEQ_PERF_EN adds retired/stall_cycles counters.
module ctrl_seq #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  ctrl_seq_if.master  bus
`ifdef CTRL_SEQ_PERF_EN
  ,
  output logic [31:0] retired,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OPC_R   = 6'b000000;
  localparam logic [5:0] OPC_LW  = 6'b000100;
  localparam logic [5:0] OPC_SW  = 6'b000101;
  localparam logic [5:0] OPC_J   = 6'b001000;
  localparam logic [5:0] OPC_BEQ = 6'b001001;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  state_t      r_state;
  logic [23:0] r_ir;
  logic [7:0]  r_cnt;
  logic        r_imem_req;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic        r_pc_en;
  logic [1:0]  r_pc_sel;
  logic        r_reg_we;
  logic        r_mem_to_reg;
  logic [2:0]  r_alu_op;
  logic        r_trap;
  logic [1:0]  r_trap_cause;

  logic        w_illegal;
  logic        w_is_sw;
  logic        w_imem_hs;
  logic        w_dmem_hs;
  logic [7:0]  w_cnt_inc;
  logic        w_timeout;
  logic        w_beq_exec;
  logic        w_trap_go;
  logic [1:0]  w_trap_code;

  // opcode legality from the splitter field
  always_comb begin
    w_illegal = 1'b1;
    case (bus.opc)
      OPC_R, OPC_LW, OPC_SW, OPC_J, OPC_BEQ: w_illegal = 1'b0;
      default:                               w_illegal = 1'b1;
    endcase
  end

  assign w_is_sw    = (bus.opc == OPC_SW);
  // acks only count while the matching request is actually being held
  assign w_imem_hs  = (r_state == S_FETCH) && r_imem_req && bus.imem_ack;
  assign w_dmem_hs  = (r_state == S_MEM) && r_dmem_req && bus.dmem_ack;
  assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_timeout  = (w_cnt_inc == TMO);
  assign w_beq_exec = (r_state == S_EXEC) && (bus.opc == OPC_BEQ);

  // fault detection; an ack in the timeout cycle takes priority
  always_comb begin
    w_trap_go   = 1'b0;
    w_trap_code = 2'd0;
    case (r_state)
      S_FETCH: begin
        if (r_imem_req && !bus.imem_ack && w_timeout) begin
          w_trap_go   = 1'b1;
          w_trap_code = CAUSE_IMEM;
        end
      end
      S_DECODE, S_EXEC: begin
        if (w_illegal) begin
          w_trap_go   = 1'b1;
          w_trap_code = CAUSE_ILLEGAL;
        end
      end
      S_MEM: begin
        if (r_dmem_req && !bus.dmem_ack && w_timeout) begin
          w_trap_go   = 1'b1;
          w_trap_code = CAUSE_DMEM;
        end
      end
      default: begin
        w_trap_go   = 1'b0;
        w_trap_code = 2'd0;
      end
    endcase
  end

  // sequencer: state, instruction register, wait counter and registered strobes
  // (each transition loads the strobe values belonging to the state being entered)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_ir         <= '0;
      r_cnt        <= '0;
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_pc_en      <= 1'b0;
      r_pc_sel     <= 2'd0;
      r_reg_we     <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_op     <= 3'd0;
      r_trap       <= 1'b0;
      r_trap_cause <= 2'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_imem_req) begin
            // first cycle out of reset: raise the request
            r_imem_req <= 1'b1;
            r_cnt      <= '0;
          end else if (w_imem_hs) begin
            r_ir       <= bus.imem_rdata;
            r_imem_req <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_DECODE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DECODE: begin
          r_cnt   <= '0;
          r_state <= S_EXEC;
          case (bus.opc)
            OPC_R:   r_alu_op <= bus.funcode;
            OPC_BEQ: r_alu_op <= 3'b001;
            default: r_alu_op <= 3'b000;
          endcase
          r_pc_en  <= (bus.opc == OPC_J) || (bus.opc == OPC_BEQ);
          r_pc_sel <= (bus.opc == OPC_J)   ? 2'd1 :
                      (bus.opc == OPC_BEQ) ? 2'd2 : 2'd0;
        end
        S_EXEC: begin
          r_cnt    <= '0;
          r_pc_en  <= 1'b0;
          r_pc_sel <= 2'd0;
          case (bus.opc)
            OPC_R: begin
              r_state      <= S_WB;
              r_reg_we     <= 1'b1;
              r_mem_to_reg <= 1'b0;
              r_pc_en      <= 1'b1;
            end
            OPC_LW, OPC_SW: begin
              r_state    <= S_MEM;
              r_dmem_req <= 1'b1;
              r_dmem_we  <= w_is_sw;
            end
            default: begin
              r_state    <= S_FETCH;
              r_imem_req <= 1'b1;
              r_alu_op   <= 3'd0;
            end
          endcase
        end
        S_MEM: begin
          if (w_dmem_hs) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_cnt      <= '0;
            if (w_is_sw) begin
              r_state    <= S_FETCH;
              r_imem_req <= 1'b1;
              r_alu_op   <= 3'd0;
            end else begin
              r_state      <= S_WB;
              r_reg_we     <= 1'b1;
              r_mem_to_reg <= 1'b1;
              r_pc_en      <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WB: begin
          r_cnt        <= '0;
          r_reg_we     <= 1'b0;
          r_mem_to_reg <= 1'b0;
          r_pc_en      <= 1'b0;
          r_pc_sel     <= 2'd0;
          r_alu_op     <= 3'd0;
          r_imem_req   <= 1'b1;
          r_state      <= S_FETCH;
        end
        default: begin
          r_state <= S_TRAP;
        end
      endcase

      // trap entry overrides whatever the state case scheduled
      if (w_trap_go) begin
        r_state      <= S_TRAP;
        r_trap       <= 1'b1;
        r_trap_cause <= w_trap_code;
        r_cnt        <= '0;
        r_imem_req   <= 1'b0;
        r_dmem_req   <= 1'b0;
        r_dmem_we    <= 1'b0;
        r_pc_en      <= 1'b0;
        r_pc_sel     <= 2'd3;
        r_reg_we     <= 1'b0;
        r_mem_to_reg <= 1'b0;
        r_alu_op     <= 3'd0;
      end
    end
  end

  // Strobes are registered; the two terms that depend on a same-cycle input
  // (BEQ not taken on alu_zero, SW completion on dmem_ack) are folded in here.
  assign bus.imem_req   = r_imem_req;
  assign bus.ir         = r_ir;
  assign bus.alu_op     = r_alu_op;
  assign bus.pc_en      = r_pc_en || (w_dmem_hs && w_is_sw);
  assign bus.pc_sel     = (w_beq_exec && !bus.alu_zero) ? 2'd0 : r_pc_sel;
  assign bus.reg_we     = r_reg_we;
  assign bus.mem_to_reg = r_mem_to_reg;
  assign bus.dmem_req   = r_dmem_req;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.trap       = r_trap;
  assign bus.trap_cause = r_trap_cause;

`ifdef CTRL_SEQ_PERF_EN
  logic [31:0] r_retired;
  logic [31:0] r_stall_cycles;
  logic        w_retire;
  logic        w_stall;

  assign w_retire = ((r_state == S_EXEC) && ((bus.opc == OPC_J) || (bus.opc == OPC_BEQ)))
                 || (w_dmem_hs && w_is_sw)
                 || (r_state == S_WB);
  assign w_stall  = ((r_state == S_FETCH) && r_imem_req && !bus.imem_ack)
                 || ((r_state == S_MEM) && r_dmem_req && !bus.dmem_ack);

  // retired-instruction and stall-cycle counters, both free-running and wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired      <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_retire) r_retired <= r_retired + 32'd1;
      if (w_stall)  r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign retired      = r_retired;
  assign stall_cycles = r_stall_cycles;
`else
  // performance counters not built
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: table-driven per-cycle check of the ctrl_seq sequencer plus
// hand-written sequences for fetch timeout, ack-at-limit and reset during MEM.
module tb_ctrl_seq;

  logic clk;
  logic rst_n;

  ctrl_seq_if bus ();

  // field splitter model
  assign bus.opc     = bus.ir[23:18];
  assign bus.funcode = bus.ir[2:0];

`ifdef CTRL_SEQ_PERF_EN
  logic [31:0] retired;
  logic [31:0] stall_cycles;
`endif

  ctrl_seq #(.MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
`ifdef CTRL_SEQ_PERF_EN
    ,
    .retired      (retired),
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        iack;
    logic [23:0] rdata;
    logic        dack;
    logic        zero;
    logic [10:0] ctl;
    logic        alu_chk;
    logic [2:0]  alu;
    logic [23:0] ir;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // {imem_req, dmem_req, dmem_we, pc_en, pc_sel, reg_we, mem_to_reg, trap, trap_cause}
  function automatic logic [10:0] C(input logic ireq, input logic dreq, input logic dwe,
                                    input logic pcen, input logic [1:0] sel,
                                    input logic rwe, input logic m2r, input logic tr,
                                    input logic [1:0] cause);
    return {ireq, dreq, dwe, pcen, sel, rwe, m2r, tr, cause};
  endfunction

  function automatic logic [10:0] ctl_now();
    return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.pc_en, bus.pc_sel,
            bus.reg_we, bus.mem_to_reg, bus.trap, bus.trap_cause};
  endfunction

  task automatic add(input logic iack, input logic [23:0] rdata, input logic dack,
                     input logic zero, input logic [10:0] ctl, input logic alu_chk,
                     input logic [2:0] alu, input logic [23:0] ir);
    vec_t v;
    v.iack = iack; v.rdata = rdata; v.dack = dack; v.zero = zero;
    v.ctl = ctl; v.alu_chk = alu_chk; v.alu = alu; v.ir = ir;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iack, input logic [23:0] rdata,
                       input logic dack, input logic zero);
    bus.imem_ack   = iack;
    bus.imem_rdata = rdata;
    bus.dmem_ack   = dack;
    bus.alu_zero   = zero;
  endtask

  // reset asserted across two edges, released just after a rising edge
  task automatic do_reset();
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [10:0] Z  = 11'b000_0_00_0_0_0_00;
  localparam logic [10:0] FR = 11'b100_0_00_0_0_0_00;
  localparam logic [10:0] TR = 11'b000_0_11_0_0_1_00;

  initial begin
    logic [10:0] dreq_only;
    logic [10:0] trap1;
    dreq_only = C(0, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0);
    trap1     = TR | 11'd1;

    // ---------- instruction stream table ----------
    add(0, 24'h0,      0, 0, Z,  1, 3'd0, 24'h000000);                          // post-reset FETCH, no req yet
    // R-type 0x002A05
    add(1, 24'h002A05, 0, 0, FR, 0, 3'd0, 24'h000000);
    add(0, 24'h0,      0, 0, Z,  0, 3'd0, 24'h002A05);                          // DECODE
    add(0, 24'h0,      0, 0, Z,  1, 3'd5, 24'h002A05);                          // EXEC alu_op=funcode
    add(0, 24'h0,      0, 0, C(0,0,0,1,2'd0,1,0,0,2'd0), 0, 3'd0, 24'h002A05);  // WB
    // LW 0x104007, dmem_ack after 3 wait cycles
    add(1, 24'h104007, 0, 0, FR, 0, 3'd0, 24'h002A05);
    add(0, 24'h0,      0, 0, Z,  0, 3'd0, 24'h104007);
    add(0, 24'h0,      0, 0, Z,  1, 3'd0, 24'h104007);                          // EXEC add
    add(0, 24'h0,      0, 0, dreq_only, 0, 3'd0, 24'h104007);
    add(0, 24'h0,      0, 0, dreq_only, 0, 3'd0, 24'h104007);
    add(0, 24'h0,      0, 0, dreq_only, 0, 3'd0, 24'h104007);
    add(0, 24'h0,      1, 0, dreq_only, 0, 3'd0, 24'h104007);
    add(0, 24'h0,      0, 0, C(0,0,0,1,2'd0,1,1,0,2'd0), 0, 3'd0, 24'h104007);  // WB from memory
    // SW 0x140002 with one fetch wait
    add(0, 24'h0,      0, 0, FR, 0, 3'd0, 24'h104007);
    add(1, 24'h140002, 0, 0, FR, 0, 3'd0, 24'h104007);
    add(0, 24'h0,      0, 0, Z,  0, 3'd0, 24'h140002);
    add(0, 24'h0,      0, 0, Z,  1, 3'd0, 24'h140002);
    add(0, 24'h0,      1, 0, C(0,1,1,1,2'd0,0,0,0,2'd0), 0, 3'd0, 24'h140002);  // MEM ack: pc_en
    // J 0x2000AB, stray acks in DECODE/EXEC must be ignored
    add(1, 24'h2000AB, 0, 0, FR, 0, 3'd0, 24'h140002);
    add(1, 24'hFFFFFF, 1, 0, Z,  0, 3'd0, 24'h2000AB);
    add(0, 24'h0,      1, 0, C(0,0,0,1,2'd1,0,0,0,2'd0), 0, 3'd0, 24'h2000AB);
    // BEQ 0x240003 taken
    add(1, 24'h240003, 0, 0, FR, 0, 3'd0, 24'h2000AB);
    add(0, 24'h0,      0, 0, Z,  0, 3'd0, 24'h240003);
    add(0, 24'h0,      0, 1, C(0,0,0,1,2'd2,0,0,0,2'd0), 1, 3'd1, 24'h240003);
    // BEQ 0x240003 not taken
    add(1, 24'h240003, 0, 0, FR, 0, 3'd0, 24'h240003);
    add(0, 24'h0,      0, 0, Z,  0, 3'd0, 24'h240003);
    add(0, 24'h0,      0, 0, C(0,0,0,1,2'd0,0,0,0,2'd0), 1, 3'd1, 24'h240003);
    // illegal opcode 0x3F
    add(1, 24'hFC0000, 0, 0, FR, 0, 3'd0, 24'h240003);
    add(0, 24'h0,      0, 0, Z,  0, 3'd0, 24'hFC0000);
    for (int i = 0; i < 3; i++)
      add(1, 24'h002A05, 1, 0, trap1, 1, 3'd0, 24'hFC0000);

    // ---------- reset state ----------
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    chk("reset_ctl", 32'(ctl_now()), 32'(Z));
    chk("reset_ir", 32'(bus.ir), 32'h0);
    chk("reset_alu", 32'(bus.alu_op), 32'h0);
    do_reset();

    // ---------- table ----------
    for (int unsigned i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iack, tbl[i].rdata, tbl[i].dack, tbl[i].zero);
      @(negedge clk);
      chk($sformatf("row%0d_ctl", i), 32'(ctl_now()), 32'(tbl[i].ctl));
      chk($sformatf("row%0d_ir", i), 32'(bus.ir), 32'(tbl[i].ir));
      if (tbl[i].alu_chk)
        chk($sformatf("row%0d_alu", i), 32'(bus.alu_op), 32'(tbl[i].alu));
      next_cycle();
    end

    // ---------- fetch timeout: 15 unanswered request cycles, then trap 2 ----------
    do_reset();
    @(negedge clk);
    chk("tmo_first_idle", 32'(ctl_now()), 32'(Z));
    next_cycle();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("tmo_wait%0d", k), 32'(ctl_now()), 32'(FR));
      next_cycle();
    end
    @(negedge clk);
    chk("tmo_trap", 32'(ctl_now()), 32'(TR | 11'd2));
    next_cycle();
    @(negedge clk);
    chk("tmo_trap_sticky", 32'(ctl_now()), 32'(TR | 11'd2));

    // ---------- ack on the 15th wait cycle wins ----------
    do_reset();
    next_cycle();
    for (int k = 1; k <= 14; k++) next_cycle();
    drive(1'b1, 24'h002A05, 1'b0, 1'b0);
    @(negedge clk);
    chk("ack15_req", 32'(ctl_now()), 32'(FR));
    next_cycle();
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ack15_decode", 32'(ctl_now()), 32'(Z));
    chk("ack15_ir", 32'(bus.ir), 32'h002A05);

    // ---------- reset during MEM of an SW ----------
    do_reset();
    next_cycle();
    drive(1'b1, 24'h140002, 1'b0, 1'b0);
    next_cycle();                        // FETCH ack taken
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    next_cycle();                        // DECODE
    next_cycle();                        // EXEC
    @(negedge clk);
    chk("swrst_mem", 32'(ctl_now()), 32'(C(0,1,1,0,2'd0,0,0,0,2'd0)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("swrst_drop", 32'(ctl_now()), 32'(Z));
    bus.dmem_ack = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    chk("swrst_idle", 32'(ctl_now()), 32'(Z));
    next_cycle();
    @(negedge clk);
    chk("swrst_refetch", 32'(ctl_now()), 32'(FR));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
